// File: rtl/vote_button_array_if.sv
// Vote button array bus: voting window, raw buttons and the qualified-vote outputs.
interface vote_button_array_if #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = $clog2(NUM_CH)
) ();
  logic              enable;
  logic [NUM_CH-1:0] button;
  logic              valid_vote;
  logic [CH_W-1:0]   vote_ch;
  logic [NUM_CH-1:0] vote_onehot;
  logic              conflict;
  logic              busy;

  // Stimulus side: opens the window and presses buttons, observes votes.
  modport master (
    output enable, button,
    input  valid_vote, vote_ch, vote_onehot, conflict, busy
  );

  // Design side: consumes buttons, reports votes and conflicts.
  modport slave (
    input  enable, button,
    output valid_vote, vote_ch, vote_onehot, conflict, busy
  );
endinterface

// File: rtl/vote_button_array.sv
// Vote button array: synchronizes raw buttons, qualifies a single button held for
// HOLD_CYCLES consecutive cycles as a vote, flags simultaneous presses as conflicts
// and locks out further votes until every button has been released.
module vote_button_array #(
  parameter int NUM_CH      = 4,
  parameter int HOLD_CYCLES = 100000000,
  parameter int CH_W        = $clog2(NUM_CH)
) (
  input logic                 clock,
  input logic                 reset,
  vote_button_array_if.slave  bus
);

  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_CYCLES);

  typedef enum logic [1:0] {IDLE, HOLD, LOCK} state_t;

  logic [NUM_CH-1:0] sync1_reg, sync2_reg;
  logic [NUM_CH-1:0] sb;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  count_reg, count_next;
  logic [CH_W-1:0]   cap_reg, cap_next;
  logic              valid_reg, valid_next;
  logic              conflict_reg, conflict_next;
  logic [CH_W-1:0]   vote_ch_reg, vote_ch_next;
  logic [NUM_CH-1:0] onehot_reg, onehot_next;

  logic              single_press;
  logic              multi_press;
  logic [CH_W-1:0]   sb_index;
  logic [NUM_CH-1:0] cap_mask;
  logic              cap_high;
  logic              other_high;

  // Two-flop synchronizer for the asynchronous buttons.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= bus.button;
      sync2_reg <= sync1_reg;
    end
  end

  assign sb = sync2_reg;

  // Classify the synchronized vector: none, exactly one, or several buttons.
  always_comb begin
    single_press = (sb != '0) && ((sb & (sb - NUM_CH'(1))) == '0);
    multi_press  = (sb != '0) && !single_press;
    sb_index     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sb[i]) sb_index = CH_W'(i);
    end
    cap_mask          = '0;
    cap_mask[cap_reg] = 1'b1;
    cap_high          = |(sb & cap_mask);
    other_high        = |(sb & ~cap_mask);
  end

  // State, hold counter, captured channel and registered output pulses.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= IDLE;
      count_reg    <= '0;
      cap_reg      <= '0;
      valid_reg    <= 1'b0;
      conflict_reg <= 1'b0;
      vote_ch_reg  <= '0;
      onehot_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      cap_reg      <= cap_next;
      valid_reg    <= valid_next;
      conflict_reg <= conflict_next;
      vote_ch_reg  <= vote_ch_next;
      onehot_reg   <= onehot_next;
    end
  end

  // Next-state logic; a release or closed window in HOLD wins over qualification.
  always_comb begin
    state_next    = state_reg;
    count_next    = count_reg;
    cap_next      = cap_reg;
    valid_next    = 1'b0;
    conflict_next = 1'b0;
    vote_ch_next  = '0;
    onehot_next   = '0;
    case (state_reg)
      IDLE: begin
        count_next = '0;
        if (bus.enable) begin
          if (single_press) begin
            state_next = HOLD;
            cap_next   = sb_index;
            count_next = CNT_W'(1);
          end else if (multi_press) begin
            state_next    = LOCK;
            conflict_next = 1'b1;
          end
        end
      end
      HOLD: begin
        if (!cap_high || !bus.enable) begin
          state_next = IDLE;
          count_next = '0;
        end else if (other_high) begin
          state_next    = LOCK;
          conflict_next = 1'b1;
          count_next    = '0;
        end else if (count_reg == HOLD_MAX) begin
          state_next   = LOCK;
          valid_next   = 1'b1;
          vote_ch_next = cap_reg;
          onehot_next  = cap_mask;
          count_next   = '0;
        end else if (count_reg < HOLD_MAX) begin
          count_next = count_reg + CNT_W'(1);
        end
      end
      LOCK: begin
        count_next = '0;
        if (sb == '0) state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        count_next = '0;
      end
    endcase
  end

  assign bus.valid_vote  = valid_reg;
  assign bus.vote_ch     = vote_ch_reg;
  assign bus.vote_onehot = onehot_reg;
  assign bus.conflict    = conflict_reg;
  assign bus.busy        = (state_reg != IDLE);

endmodule

// File: tb/tb_vote_button_array.sv
// Testbench for vote_button_array: directed scenarios plus randomized presses,
// all checked cycle by cycle against a behavioural model of the voting rules.
module tb_vote_button_array;
  localparam int NUM_CH = 4;
  localparam int HOLD   = 8;
  localparam int CH_W   = 2;
  localparam int VW     = 1 + CH_W + NUM_CH + 1 + 1;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  vote_button_array_if #(.NUM_CH(NUM_CH), .CH_W(CH_W)) bus ();

  vote_button_array #(.NUM_CH(NUM_CH), .HOLD_CYCLES(HOLD), .CH_W(CH_W)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int passed = 0;
  int total  = 0;

  // Behavioural model: buttons reach the voting logic two clocks late; a voter
  // "holds" a channel for a run of cycles, and a lockout lasts until all are released.
  logic [NUM_CH-1:0] m_s1 = '0, m_s2 = '0;
  bit m_locked = 1'b0;
  int m_held   = -1;
  int m_run    = 0;
  bit m_valid  = 1'b0;
  bit m_conf   = 1'b0;
  int m_ch     = 0;

  always @(posedge clock) begin
    logic [NUM_CH-1:0] sb;
    sb      = m_s2;
    m_valid = 1'b0;
    m_conf  = 1'b0;
    if (reset) begin
      m_s1 = '0; m_s2 = '0; m_locked = 1'b0; m_held = -1; m_run = 0;
    end else begin
      if (m_locked) begin
        if (sb == '0) m_locked = 1'b0;
      end else if (m_held < 0) begin
        if (bus.enable && $countones(sb) == 1) begin
          for (int i = 0; i < NUM_CH; i++) if (sb[i]) m_held = i;
          m_run = 1;
        end else if (bus.enable && $countones(sb) > 1) begin
          m_locked = 1'b1; m_conf = 1'b1;
        end
      end else if (!sb[m_held] || !bus.enable) begin
        m_held = -1; m_run = 0;
      end else if ($countones(sb) > 1) begin
        m_locked = 1'b1; m_conf = 1'b1; m_held = -1;
      end else if (m_run == HOLD) begin
        m_valid = 1'b1; m_ch = m_held; m_locked = 1'b1; m_held = -1;
      end else begin
        m_run++;
      end
      m_s2 = m_s1;
      m_s1 = bus.button;
    end
  end

  function automatic logic [VW-1:0] model_vec();
    logic [NUM_CH-1:0] oh;
    logic [CH_W-1:0]   ch;
    oh = '0;
    ch = '0;
    if (m_valid) begin
      oh[m_ch] = 1'b1;
      ch       = CH_W'(m_ch);
    end
    return {m_valid, ch, oh, m_conf, (m_locked || m_held >= 0)};
  endfunction

  // One clock: apply inputs after a falling edge, sample outputs at the next falling edge.
  // Vector layout: {valid[8], vote_ch[7:6], onehot[5:2], conflict[1], busy[0]}.
  task automatic drive_cycle(input bit en, input logic [NUM_CH-1:0] btn,
                             output logic [VW-1:0] got, output logic [VW-1:0] exp);
    bus.enable = en;
    bus.button = btn;
    @(posedge clock);
    @(negedge clock);
    got = {bus.valid_vote, (bus.valid_vote ? bus.vote_ch : {CH_W{1'b0}}),
           bus.vote_onehot, bus.conflict, bus.busy};
    exp = model_vec();
  endtask

  task automatic test_reset();
    logic [VW-1:0] got, exp;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b1, 4'b0101, got, exp);
      total++;
      if (got !== '0) $display("FAIL reset cyc %0d: got %b want %b", i, got, {VW{1'b0}});
      else passed++;
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b1, '0, got, exp);
      total++;
      if (got !== exp) $display("FAIL reset_idle cyc %0d: got %b want %b", i, got, exp);
      else passed++;
    end
  endtask

  task automatic test_single_vote();
    logic [VW-1:0] got, exp;
    int vcnt = 0, vcyc = -1;
    logic [VW-1:0] vgot = '0;
    for (int i = 1; i <= 20; i++) begin
      drive_cycle(1'b1, 4'b0100, got, exp);
      total++;
      if (got !== exp) $display("FAIL single_vote cyc %0d: got %b want %b", i, got, exp);
      else passed++;
      if (got[8]) begin vcnt++; if (vcyc < 0) begin vcyc = i; vgot = got; end end
    end
    total++;
    if (vcnt != 1 || vcyc != 11) $display("FAIL single_vote_latency: got %0d pulses at cyc %0d want 1 at 11", vcnt, vcyc);
    else passed++;
    total++;
    if (vgot[7:2] !== 6'b10_0100) $display("FAIL single_vote_ch: got %b want %b", vgot[7:2], 6'b10_0100);
    else passed++;
    total++;
    if (got[0] !== 1'b1) $display("FAIL single_vote_busy: got %b want 1", got[0]);
    else passed++;
    for (int i = 1; i <= 4; i++) begin
      drive_cycle(1'b1, '0, got, exp);
      total++;
      if (got !== exp) $display("FAIL single_release cyc %0d: got %b want %b", i, got, exp);
      else passed++;
    end
  endtask

  task automatic test_release_early();
    logic [VW-1:0] got, exp;
    int vcnt = 0;
    for (int i = 1; i <= 6; i++) begin
      drive_cycle(1'b1, 4'b0001, got, exp);
      total++;
      if (got !== exp) $display("FAIL early_hold cyc %0d: got %b want %b", i, got, exp);
      else passed++;
      if (got[8]) vcnt++;
    end
    for (int i = 1; i <= 4; i++) begin
      drive_cycle(1'b1, '0, got, exp);
      total++;
      if (got !== exp) $display("FAIL early_release cyc %0d: got %b want %b", i, got, exp);
      else passed++;
      if (got[8]) vcnt++;
      if (i == 2 || i == 3) begin
        total++;
        if (got[0] !== (i == 2)) $display("FAIL early_busy cyc %0d: got %b want %b", i, got[0], (i == 2));
        else passed++;
      end
    end
    total++;
    if (vcnt != 0) $display("FAIL early_novote: got %0d pulses want 0", vcnt);
    else passed++;
  endtask

  task automatic test_conflict();
    logic [VW-1:0] got, exp;
    int ccnt = 0, vcnt = 0;
    for (int i = 1; i <= 12; i++) begin
      drive_cycle(1'b1, 4'b0011, got, exp);
      total++;
      if (got !== exp) $display("FAIL conflict cyc %0d: got %b want %b", i, got, exp);
      else passed++;
      ccnt += got[1]; vcnt += got[8];
    end
    total++;
    if (ccnt != 1 || vcnt != 0 || got[0] !== 1'b1)
      $display("FAIL conflict_once: got conflicts %0d votes %0d busy %b want 1 0 1", ccnt, vcnt, got[0]);
    else passed++;
    for (int i = 1; i <= 4; i++) begin
      drive_cycle(1'b1, '0, got, exp);
      total++;
      if (got !== exp) $display("FAIL conflict_release cyc %0d: got %b want %b", i, got, exp);
      else passed++;
    end
    total++;
    if (got[0] !== 1'b0) $display("FAIL conflict_idle: got busy %b want 0", got[0]);
    else passed++;
  endtask

  task automatic test_late_conflict();
    logic [VW-1:0] got, exp;
    int ccnt = 0, vcnt = 0, vch = -1;
    for (int i = 1; i <= 14; i++) begin
      drive_cycle(1'b1, (i <= 4) ? 4'b1000 : 4'b1010, got, exp);
      total++;
      if (got !== exp) $display("FAIL late_conflict cyc %0d: got %b want %b", i, got, exp);
      else passed++;
      ccnt += got[1]; vcnt += got[8];
    end
    total++;
    if (ccnt != 1 || vcnt != 0) $display("FAIL late_conflict_once: got conflicts %0d votes %0d want 1 0", ccnt, vcnt);
    else passed++;
    vcnt = 0;
    for (int i = 1; i <= 24; i++) begin
      drive_cycle(1'b1, (i > 4 && i <= 14) ? 4'b0010 : 4'b0000, got, exp);
      total++;
      if (got !== exp) $display("FAIL late_revote cyc %0d: got %b want %b", i, got, exp);
      else passed++;
      if (got[8]) begin vcnt++; vch = int'(got[7:6]); end
    end
    total++;
    if (vcnt != 1 || vch != 1) $display("FAIL late_revote_ch: got %0d votes ch %0d want 1 vote ch 1", vcnt, vch);
    else passed++;
  endtask

  task automatic test_enable();
    logic [VW-1:0] got, exp;
    int vcnt = 0;
    for (int i = 1; i <= 20; i++) begin
      drive_cycle(1'b0, 4'b0001, got, exp);
      total++;
      if (got !== '0 || got !== exp) $display("FAIL enable_low cyc %0d: got %b want %b", i, got, {VW{1'b0}});
      else passed++;
    end
    drive_cycle(1'b0, '0, got, exp);
    drive_cycle(1'b0, '0, got, exp);
    for (int i = 1; i <= 22; i++) begin
      drive_cycle(i <= 7, (i <= 17) ? 4'b0001 : 4'b0000, got, exp);
      total++;
      if (got !== exp) $display("FAIL enable_drop cyc %0d: got %b want %b", i, got, exp);
      else passed++;
      vcnt += got[8];
    end
    total++;
    if (vcnt != 0 || got[0] !== 1'b0) $display("FAIL enable_abort: got votes %0d busy %b want 0 0", vcnt, got[0]);
    else passed++;
  endtask

  task automatic test_reset_mid();
    logic [VW-1:0] got, exp;
    int vcyc = -1, vcnt = 0;
    for (int i = 1; i <= 8; i++) begin
      drive_cycle(1'b1, 4'b0001, got, exp);
      total++;
      if (got !== exp) $display("FAIL reset_mid_hold cyc %0d: got %b want %b", i, got, exp);
      else passed++;
    end
    reset = 1'b1;
    drive_cycle(1'b1, 4'b0001, got, exp);
    reset = 1'b0;
    total++;
    if (got !== '0) $display("FAIL reset_mid_clear: got %b want %b", got, {VW{1'b0}});
    else passed++;
    for (int i = 1; i <= 14; i++) begin
      drive_cycle(1'b1, 4'b0001, got, exp);
      total++;
      if (got !== exp) $display("FAIL reset_mid_repress cyc %0d: got %b want %b", i, got, exp);
      else passed++;
      if (got[8]) begin vcnt++; if (vcyc < 0) vcyc = i; end
    end
    total++;
    if (vcnt != 1 || vcyc != 11) $display("FAIL reset_mid_latency: got %0d pulses at cyc %0d want 1 at 11", vcnt, vcyc);
    else passed++;
    for (int i = 1; i <= 4; i++) drive_cycle(1'b1, '0, got, exp);
  endtask

  task automatic test_random();
    logic [VW-1:0] got, exp;
    logic [NUM_CH-1:0] pat;
    bit en;
    int run, cyc;
    cyc = 0;
    while (cyc < 600) begin
      case ($urandom_range(0, 5))
        0:       pat = NUM_CH'($urandom);
        1:       pat = '0;
        default: pat = NUM_CH'(1) << $urandom_range(0, NUM_CH - 1);
      endcase
      en  = ($urandom_range(0, 7) != 0);
      run = $urandom_range(1, 14);
      for (int k = 0; k < run; k++) begin
        reset = ($urandom_range(0, 99) == 0);
        drive_cycle(en, pat, got, exp);
        cyc++;
        total++;
        if (got !== exp) $display("FAIL random cyc %0d: got %b want %b", cyc, got, exp);
        else passed++;
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    bus.enable = 1'b0;
    bus.button = '0;
    @(negedge clock);
    test_reset();
    test_single_vote();
    test_release_early();
    test_conflict();
    test_late_conflict();
    test_enable();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/vote_button_array.md
VOTE_BUTTON_ARRAY -- requirements
Module: vote_button_array

Interface
REQ-001 Parameter NUM_CH, default 4, number of vote button channels (2..16).
REQ-002 Parameter HOLD_CYCLES, default 100000000, consecutive synchronized-high cycles required to qualify a vote (>=2).
REQ-003 Parameter CH_W, default $clog2(NUM_CH), width of the channel index output.
REQ-004 clock  input  1  rising-edge system clock.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 enable  input  1  voting window open; low blocks new votes.
REQ-007 button  input  NUM_CH  raw asynchronous push buttons, bit i = channel i, active-high.
REQ-008 valid_vote  output  1  one-cycle pulse, qualified vote issued.
REQ-009 vote_ch  output  CH_W  index of voted channel, valid while valid_vote=1.
REQ-010 vote_onehot  output  NUM_CH  one-hot of voted channel, valid while valid_vote=1, else zero.
REQ-011 conflict  output  1  one-cycle pulse, multiple buttons pressed simultaneously.
REQ-012 busy  output  1  high in states HOLD and LOCK.

Function
REQ-013 Each button bit SHALL pass through a 2-flop synchronizer; all rules below use the synchronized vector sb.
REQ-014 FSM states SHALL be IDLE, HOLD, LOCK; a single hold counter of $clog2(HOLD_CYCLES+1) bits and a captured-channel register SHALL be kept.
REQ-015 IDLE: enable=1 and exactly one sb bit high -> HOLD, capture channel, counter=1.
REQ-016 IDLE: enable=1 and two or more sb bits high -> LOCK, conflict pulses for one cycle.
REQ-017 IDLE: enable=0 -> stay IDLE regardless of sb; counter=0.
REQ-018 HOLD: captured bit high, no other bit high, enable=1, counter<HOLD_CYCLES -> counter increments by 1.
REQ-019 HOLD: counter==HOLD_CYCLES and captured bit still high -> valid_vote=1, vote_ch/vote_onehot set for exactly the next cycle, state -> LOCK.
REQ-020 Vote latency SHALL be HOLD_CYCLES+1 clocks after first sb-high cycle (HOLD_CYCLES+3 from raw button edge).
REQ-021 HOLD: captured bit low before qualification -> IDLE, counter=0, no output pulse.
REQ-022 HOLD: any other bit goes high -> LOCK, conflict pulses, no vote.
REQ-023 HOLD: enable falls -> IDLE, counter=0, no vote; enable low SHALL never produce a vote.
REQ-024 LOCK: stay until sb==0 for one cycle, then IDLE; a held button SHALL never produce a second vote.
REQ-025 Counter SHALL saturate and never wrap; no vote SHALL issue from a counter wrap.
REQ-026 valid_vote and conflict SHALL never be high in the same cycle.
REQ-027 Releasing the captured button in the same cycle counter reaches HOLD_CYCLES SHALL abort (REQ-021 takes priority).

Reset
REQ-028 reset=1 SHALL force state IDLE, counter=0, synchronizer flops=0, valid_vote=0, vote_ch=0, vote_onehot=0, conflict=0, busy=0 on the next edge.
REQ-029 reset asserted mid-HOLD or LOCK SHALL discard progress; after release a still-held button SHALL be treated as a new press from IDLE.

Verification (HOLD_CYCLES=8, NUM_CH=4)
REQ-030 enable=1, button=0100 held 20 cycles -> single valid_vote pulse 11 clocks after press, vote_ch=2, vote_onehot=0100, then busy until release.
REQ-031 button=0001 held 6 cycles then released -> no valid_vote, state IDLE, busy low 3 cycles after release.
REQ-032 button=0011 pressed same cycle -> conflict pulse once, no vote, busy until both released.
REQ-033 button=1000 held, button 0010 added after 4 cycles -> conflict pulse, no vote; release both, press 0010 alone 10 cycles -> vote_ch=1.
REQ-034 enable=0, button=0001 held 20 cycles -> no outputs; enable dropped at counter=5 -> abort, no vote.
REQ-035 reset pulsed at counter=6 while button held -> all outputs 0; vote issued 11 clocks after reset release.
